// File: rtl/pwm_dc_sequencer.sv
// Register-programmed duty-cycle sequencer: steps a small table of duty values into a PWM core
// at each period boundary. Define PWM_SEQ_IRQ_EN to build the sequence-done interrupt (CTRL.ie).
module pwm_dc_sequencer #(
  parameter int DEPTH = 8,
  parameter int DCW   = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           re_i,
  input  logic           we_i,
  input  logic [7:0]     addr_i,
  input  logic [31:0]    wdata_i,
  output logic [31:0]    rdata_o,
  input  logic           period_end_i,
  output logic [DCW-1:0] dc_o,
  output logic           dc_valid_o,
  output logic           busy_o,
  output logic           irq_o
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;

  state_t         state, state_n;
  logic [IW-1:0]  idx, idx_n;
  logic [CW-1:0]  idx_p1;
  logic [CW-1:0]  count;
  logic           loop, done, ovf, set_done;
  logic           ie;
  logic [DCW-1:0] tbl [DEPTH];

  logic wr_ctrl, wr_tbl, wr_stat, wr_clr, start_w, stop_w, full, empty, idle;
  logic unused_wdata;

  assign wr_ctrl = we_i && (addr_i == 8'h00);
  assign wr_tbl  = we_i && (addr_i == 8'h04);
  assign wr_stat = we_i && (addr_i == 8'h08);
  assign wr_clr  = we_i && (addr_i == 8'h0C);
  assign start_w = wr_ctrl && wdata_i[0];
  assign stop_w  = wr_ctrl && wdata_i[2];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign idle    = (state == IDLE);
  assign busy_o  = !idle;
  assign idx_p1  = {1'b0, idx} + CW'(1);
  assign unused_wdata = &{1'b0, wdata_i};

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    set_done = 1'b0;
    case (state)
      IDLE:  if (start_w && !stop_w && !empty) state_n = ISSUE;
      ISSUE: state_n = stop_w ? IDLE : RUN;
      RUN: begin
        // stop outranks a coincident period boundary
        if (stop_w) state_n = IDLE;
        else if (period_end_i) begin
          if (idx_p1 < count) begin
            idx_n   = idx_p1[IW-1:0];
            state_n = ISSUE;
          end else if (loop) begin
            idx_n   = '0;
            state_n = ISSUE;
          end else begin
            state_n  = IDLE;
            set_done = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) idx_n = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      idx        <= '0;
      dc_o       <= '0;
      dc_valid_o <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      dc_valid_o <= (state_n == ISSUE);
      if (state_n == ISSUE) dc_o <= tbl[idx_n];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
      loop  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (wr_ctrl) loop <= wdata_i[1];
      // table and clear writes only land while idle; busy pushes vanish silently
      if (wr_tbl && idle && !full) count <= count + CW'(1);
      else if (wr_clr && idle)     count <= '0;
      if (set_done)                    done <= 1'b1;
      else if (wr_stat && wdata_i[3])  done <= 1'b0;
      if (wr_tbl && idle && full)      ovf  <= 1'b1;
      else if (wr_stat && wdata_i[4])  ovf  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_tbl && idle && !full) tbl[count[IW-1:0]] <= wdata_i[DCW-1:0];
  end

`ifdef PWM_SEQ_IRQ_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ie    <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (wr_ctrl) ie <= wdata_i[3];
      irq_o <= done & ie;
    end
  end
`else
  assign ie    = 1'b0;
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rdata_o = '0;
    if (re_i) begin
      case (addr_i)
        8'h00:   rdata_o = {28'd0, ie, 1'b0, loop, 1'b0};
        8'h08:   rdata_o = {16'd0, 8'(count), 3'd0, ovf, done, empty, full, busy_o};
        default: rdata_o = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_pwm_dc_sequencer.sv
// Directed bench for pwm_dc_sequencer: one task per scenario, hand-computed expectations.
module tb_pwm_dc_sequencer;
  logic        clk = 0, rst = 1, re = 0, we = 0, pe = 0;
  logic [7:0]  addr = 0;
  logic [31:0] wdata = 0, rdata, d;
  logic [15:0] dc;
  logic        dc_valid, busy, irq;
  int total = 0, bad = 0;

  pwm_dc_sequencer #(.DEPTH(8), .DCW(16)) dut (
    .clk_i(clk), .rst_i(rst), .re_i(re), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rdata), .period_end_i(pe), .dc_o(dc), .dc_valid_o(dc_valid),
    .busy_o(busy), .irq_o(irq));

  always #5 clk = ~clk;

  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    @(negedge clk); we = 1; addr = a; wdata = v;
    @(negedge clk); we = 0; wdata = 0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    @(negedge clk); re = 1; addr = a;
    #1 v = rdata; re = 0;
  endtask

  task automatic pulse_pe();
    @(negedge clk); pe = 1;
    @(negedge clk); pe = 0;
  endtask

  task automatic test_reset();
    rst = 1; repeat (2) @(negedge clk);
    total++; if (dc !== 16'h0) begin bad++; $display("FAIL reset_dc got %h exp 0", dc); end
    total++; if (dc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b exp 0", dc_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got %b exp 0", irq); end
    rst = 0;
    rd(8'h08, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL reset_status got %h exp 4", d); end
    rd(8'h00, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got %h exp 0", d); end
  endtask

  task automatic test_oneshot();
    wr(8'h04, 32'h10); wr(8'h04, 32'h20); wr(8'h04, 32'h30);
    rd(8'h08, d);
    total++; if (d !== 32'h300) begin bad++; $display("FAIL push_status got %h exp 300", d); end
    wr(8'h00, 32'h1);
    total++; if ({dc_valid, busy, dc} !== {2'b11, 16'h10}) begin bad++; $display("FAIL os_first got v=%b b=%b dc=%h exp 1 1 0010", dc_valid, busy, dc); end
    @(negedge clk);
    total++; if (dc_valid !== 1'b0) begin bad++; $display("FAIL os_valid_drop got %b exp 0", dc_valid); end
    pulse_pe();
    total++; if ({dc_valid, dc} !== {1'b1, 16'h20}) begin bad++; $display("FAIL os_second got v=%b dc=%h exp 1 0020", dc_valid, dc); end
    pulse_pe();
    total++; if ({dc_valid, dc} !== {1'b1, 16'h30}) begin bad++; $display("FAIL os_third got v=%b dc=%h exp 1 0030", dc_valid, dc); end
    pulse_pe();
    total++; if ({dc_valid, busy, dc} !== {2'b00, 16'h30}) begin bad++; $display("FAIL os_end got v=%b b=%b dc=%h exp 0 0 0030", dc_valid, busy, dc); end
    rd(8'h08, d);
    total++; if (d !== 32'h308) begin bad++; $display("FAIL os_done got %h exp 308", d); end
    wr(8'h08, 32'h8);
    rd(8'h08, d);
    total++; if (d !== 32'h300) begin bad++; $display("FAIL os_done_w1c got %h exp 300", d); end
  endtask

  task automatic test_loop();
    logic [15:0] exp_seq [4] = '{16'h20, 16'h30, 16'h10, 16'h20};
    wr(8'h00, 32'h3);
    total++; if ({dc_valid, dc} !== {1'b1, 16'h10}) begin bad++; $display("FAIL loop_first got v=%b dc=%h exp 1 0010", dc_valid, dc); end
    for (int i = 0; i < 4; i++) begin
      pulse_pe();
      total++; if ({dc_valid, busy, dc} !== {2'b11, exp_seq[i]}) begin bad++; $display("FAIL loop_step%0d got v=%b b=%b dc=%h exp 1 1 %h", i, dc_valid, busy, dc, exp_seq[i]); end
    end
    wr(8'h00, 32'h4);
    total++; if ({dc_valid, busy} !== 2'b00) begin bad++; $display("FAIL loop_stop got v=%b b=%b exp 0 0", dc_valid, busy); end
    rd(8'h08, d);
    total++; if (d !== 32'h300) begin bad++; $display("FAIL loop_stop_status got %h exp 300", d); end
  endtask

  task automatic test_stop_pe();
    wr(8'h00, 32'h1);
    pulse_pe();
    @(negedge clk); we = 1; addr = 8'h00; wdata = 32'h4; pe = 1;
    @(negedge clk); we = 0; wdata = 0; pe = 0;
    total++; if ({dc_valid, busy, dc} !== {2'b00, 16'h20}) begin bad++; $display("FAIL stop_pe got v=%b b=%b dc=%h exp 0 0 0020", dc_valid, busy, dc); end
    rd(8'h08, d);
    total++; if (d !== 32'h300) begin bad++; $display("FAIL stop_pe_status got %h exp 300", d); end
  endtask

  task automatic test_start_ignored();
    wr(8'h0C, 32'h0);
    rd(8'h08, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL clear_status got %h exp 4", d); end
    wr(8'h00, 32'h1);
    total++; if ({dc_valid, busy} !== 2'b00) begin bad++; $display("FAIL start_empty got v=%b b=%b exp 0 0", dc_valid, busy); end
    wr(8'h04, 32'h55);
    wr(8'h00, 32'h1);
    total++; if ({dc_valid, dc} !== {1'b1, 16'h55}) begin bad++; $display("FAIL start_one got v=%b dc=%h exp 1 0055", dc_valid, dc); end
    wr(8'h00, 32'h1);
    total++; if ({dc_valid, busy} !== 2'b01) begin bad++; $display("FAIL start_busy got v=%b b=%b exp 0 1", dc_valid, busy); end
    wr(8'h04, 32'h99);
    wr(8'h0C, 32'h0);
    rd(8'h08, d);
    total++; if (d !== 32'h101) begin bad++; $display("FAIL busy_push_clear got %h exp 101", d); end
    wr(8'h00, 32'h4);
    rd(8'h08, d);
    total++; if (d !== 32'h100) begin bad++; $display("FAIL busy_stop_status got %h exp 100", d); end
  endtask

  task automatic test_overflow();
    wr(8'h0C, 32'h0);
    for (int i = 0; i < 9; i++) wr(8'h04, 32'h100 + i);
    rd(8'h08, d);
    total++; if (d !== 32'h812) begin bad++; $display("FAIL ovf_status got %h exp 812", d); end
    wr(8'h08, 32'h10);
    rd(8'h08, d);
    total++; if (d !== 32'h802) begin bad++; $display("FAIL ovf_w1c got %h exp 802", d); end
    wr(8'h00, 32'h1);
    repeat (7) pulse_pe();
    total++; if ({dc_valid, dc} !== {1'b1, 16'h107}) begin bad++; $display("FAIL ovf_tbl7 got v=%b dc=%h exp 1 0107", dc_valid, dc); end
    pulse_pe();
    rd(8'h08, d);
    total++; if (d !== 32'h80A) begin bad++; $display("FAIL ovf_done got %h exp 80a", d); end
    wr(8'h08, 32'h8);
  endtask

  task automatic test_irq();
    wr(8'h0C, 32'h0);
    wr(8'h04, 32'h77);
    wr(8'h00, 32'h9);
    total++; if ({dc_valid, dc} !== {1'b1, 16'h77}) begin bad++; $display("FAIL irq_start got v=%b dc=%h exp 1 0077", dc_valid, dc); end
    pulse_pe();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_pre got %b exp 0", irq); end
    @(negedge clk);
`ifdef PWM_SEQ_IRQ_EN
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set got %b exp 1", irq); end
    wr(8'h08, 32'h8);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got %b exp 0", irq); end
    rd(8'h00, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL irq_ctrl got %h exp 8", d); end
    wr(8'h00, 32'h0);
`else
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_off got %b exp 0", irq); end
    rd(8'h00, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL irq_ctrl_ie got %h exp 0", d); end
    rd(8'h08, d);
    total++; if (d !== 32'h108) begin bad++; $display("FAIL irq_done got %h exp 108", d); end
    wr(8'h08, 32'h8);
`endif
  endtask

  task automatic test_reset_mid();
    wr(8'h00, 32'h1);
    @(negedge clk); rst = 1;
    @(negedge clk);
    total++; if ({dc_valid, busy, dc} !== {2'b00, 16'h0}) begin bad++; $display("FAIL rst_mid got v=%b b=%b dc=%h exp 0 0 0000", dc_valid, busy, dc); end
    rst = 0;
    @(negedge clk);
    total++; if (dc_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_after got %b exp 0", dc_valid); end
    rd(8'h08, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL rst_mid_status got %h exp 4", d); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_loop();
    test_stop_pe();
    test_start_ignored();
    test_overflow();
    test_irq();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_dc_sequencer.md
PWM_DC_SEQUENCER -- requirements
Module: pwm_dc_sequencer

Interface
REQ-001 Parameter DEPTH, default 8: number of duty-cycle table entries (power of 2, 2..16).
REQ-002 Parameter DCW, default 16: duty-cycle value width.
REQ-003 clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 re_i  input  1  register read strobe.
REQ-006 we_i  input  1  register write strobe.
REQ-007 addr_i  input  8  register byte address.
REQ-008 wdata_i  input  32  register write data.
REQ-009 rdata_o  output  32  register read data.
REQ-010 period_end_i  input  1  one-cycle pulse from the PWM core at each period boundary.
REQ-011 dc_o  output  DCW  duty-cycle value presented to the PWM core.
REQ-012 dc_valid_o  output  1  one-cycle strobe that dc_o is a new value.
REQ-013 busy_o  output  1  high while the sequence is running.
REQ-014 irq_o  output  1  sequence-done interrupt (see Configuration).

Function
REQ-015 Registers: 0x00 CTRL; 0x04 TABLE (write-only push); 0x08 STATUS; 0x0C CLEAR (any write).
- CTRL: [0] start (W, self-clearing); [1] loop (R/W); [2] stop (W, self-clearing); [3] ie (R/W).
- STATUS: [0] busy; [1] full; [2] empty; [3] done (sticky, W1C); [4] overflow (sticky, W1C); [15:8] count.
REQ-016 rdata_o is combinational from addr_i whenever re_i is high, and is 0 otherwise or at an unmapped address.
REQ-017 A TABLE write stores wdata_i[DCW-1:0] at index count and increments count.
- When count==DEPTH, the write is dropped and overflow is set.
- When busy, the write is dropped and no flag is set.
REQ-018 A CLEAR write while idle sets count to 0; it is ignored while busy.
REQ-019 FSM states are IDLE, ISSUE and RUN.
REQ-020 IDLE -> ISSUE on a start write with count>0 and no stop in the same write; start with count==0 is ignored.
REQ-021 ISSUE lasts one cycle: dc_o <= table[idx], dc_valid_o=1, then -> RUN.
- dc_valid_o is therefore high exactly one cycle after the start write or the qualifying period_end_i.
REQ-022 RUN on period_end_i:
- If idx+1<count: idx+1, -> ISSUE.
- Else if loop: idx wraps to 0, -> ISSUE.
- Else: -> IDLE and done is set.
REQ-023 A stop write in any non-IDLE state -> IDLE next cycle and does not set done; stop wins over a simultaneous period_end_i.
REQ-024 Start while busy is ignored; period_end_i in IDLE or ISSUE is ignored.
REQ-025 idx resets to 0 on every IDLE entry.
REQ-026 dc_o holds its last issued value in IDLE.
REQ-027 busy_o = (state != IDLE).
REQ-028 Clearing loop while running takes effect at the next period_end_i with idx+1==count.

Reset
REQ-029 While rst_i is high, the following are cleared:
- State = IDLE.
- idx, count, CTRL, done and overflow = 0.
- dc_o = 0, dc_valid_o = 0, busy_o = 0, irq_o = 0.
REQ-030 Table contents are not reset.
REQ-031 Reset mid-sequence aborts the sequence with no dc_valid_o pulse.

Configuration
REQ-032 Macro PWM_SEQ_IRQ_EN:
- Defined: irq_o is registered as done & ie.
- Undefined: irq_o is tied to 0, CTRL[3] reads 0 and writes to it are ignored.

Verification
REQ-033 Push 0x0010, 0x0020, 0x0030; start with loop=0.
- Expect dc_valid_o+dc_o=0x0010 on the cycle after the write.
- Expect 0x0020 and 0x0030 one cycle after the 1st and 2nd period_end_i.
- On the 3rd period_end_i expect IDLE and done=1.
REQ-034 Same table with loop=1 and 4 period_end_i pulses.
- Expect the dc_o sequence 0x10, 0x20, 0x30, 0x10, 0x20.
- Expect busy_o to stay 1.
REQ-035 Nine pushes with DEPTH=8.
- Expect count=8, full=1, overflow=1 and table[7] unchanged.
- Then write 0x08=0x10 and expect overflow=0.
REQ-036 Stop and period_end_i in the same cycle during RUN.
- Expect IDLE next cycle, no dc_valid_o, done=0.
REQ-037 Start with count==0, and start while busy.
- Expect no state change and no dc_valid_o in both cases.
REQ-038 With PWM_SEQ_IRQ_EN and ie=1, a one-shot sequence completes.
- Expect irq_o=1 one cycle after done sets.
- Expect irq_o=0 after writing 0x08=0x08.
- Expect irq_o=0 at all times when built without the macro.
